// File: rtl/morse_key_capture.sv
// Morse key capture: synchronizes and debounces a raw key, times presses and
// releases in ticks, and packs up to five dot/dash elements into a letter code.
module morse_key_capture #(
   parameter int TICK_DIV         = 50000,
   parameter int DEBOUNCE         = 4,
   parameter int DASH_TICKS       = 30,
   parameter int LETTER_GAP_TICKS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       key_in,
   output logic [4:0] code,
   output logic [2:0] len,
   output logic       valid,
   output logic       err,
   output logic       key_level
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          key_m, key_s;
   logic [DW-1:0] db_cnt;
   logic          mismatch, toggle;
   logic          rise, fall;

   state_t        state, state_n;
   logic [4:0]    acc_code, acc_code_n;
   logic [2:0]    acc_len, acc_len_n;
   logic          ovf, ovf_n;
   logic [7:0]    dur, dur_n, dur_inc;
   logic          elem;
   logic [4:0]    code_n;
   logic [2:0]    len_n;
   logic          valid_n, err_n;

   assign tick = en && (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || !en || tick) tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_m <= 1'b0;
         key_s <= 1'b0;
      end else begin
         key_m <= key_in;
         key_s <= key_m;
      end
   end

   assign mismatch = (key_s != key_level);
   assign toggle   = tick && mismatch && (db_cnt == DW'(DEBOUNCE - 1));

   // rise/fall are registered alongside key_level, so they land one cycle after a tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_level <= 1'b0;
         db_cnt    <= '0;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         rise <= toggle && !key_level;
         fall <= toggle && key_level;
         if (!en) begin
            db_cnt <= '0;
         end else if (tick) begin
            if (toggle) begin
               key_level <= ~key_level;
               db_cnt    <= '0;
            end else if (mismatch) begin
               db_cnt <= db_cnt + 1'b1;
            end else begin
               db_cnt <= '0;
            end
         end
      end
   end

   assign dur_inc = (dur == 8'hFF) ? dur : dur + 8'd1;
   assign elem    = (dur >= 8'(DASH_TICKS));

   always_comb begin
      state_n    = state;
      acc_code_n = acc_code;
      acc_len_n  = acc_len;
      ovf_n      = ovf;
      dur_n      = dur;
      code_n     = code;
      len_n      = len;
      valid_n    = 1'b0;
      err_n      = 1'b0;
      if (!en) begin
         state_n    = IDLE;
         acc_code_n = '0;
         acc_len_n  = '0;
         ovf_n      = 1'b0;
         dur_n      = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  dur_n   = '0;
                  state_n = PRESS;
               end
            end
            PRESS: begin
               if (tick) dur_n = dur_inc;
               if (fall) begin
                  if (acc_len < 3'd5) begin
                     acc_code_n = acc_code | (5'(elem) << acc_len);
                     acc_len_n  = acc_len + 3'd1;
                  end else begin
                     ovf_n = 1'b1;
                  end
                  dur_n   = '0;
                  state_n = GAP;
               end
            end
            GAP: begin
               // A new press beats gap completion, so the letter keeps growing.
               if (rise) begin
                  dur_n   = '0;
                  state_n = PRESS;
               end else if (tick) begin
                  dur_n = dur_inc;
                  if (dur == 8'(LETTER_GAP_TICKS - 1)) begin
                     if (ovf) begin
                        err_n = 1'b1;
                     end else begin
                        code_n  = acc_code;
                        len_n   = acc_len;
                        valid_n = 1'b1;
                     end
                     acc_code_n = '0;
                     acc_len_n  = '0;
                     ovf_n      = 1'b0;
                     dur_n      = '0;
                     state_n    = IDLE;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc_code <= '0;
         acc_len  <= '0;
         ovf      <= 1'b0;
         dur      <= '0;
         code     <= '0;
         len      <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         acc_code <= acc_code_n;
         acc_len  <= acc_len_n;
         ovf      <= ovf_n;
         dur      <= dur_n;
         code     <= code_n;
         len      <= len_n;
         valid    <= valid_n;
         err      <= err_n;
      end
   end

endmodule
